// File: rtl/prbs_checker.sv
// Serial PRBS checker for the 2-tap Fibonacci LFSR stream b[n] = b[n-TAP_A] ^ b[n-TAP_B].
// It fills its history from the line, then confirms LOCK_CNT consecutive predicted bits.
// Once locked it free-runs a local reference and counts bit errors against it.
// Too many errors within one window drop it back to search.

module prbs_checker #(
   parameter int unsigned WIDTH     = 153,
   parameter int unsigned TAP_A     = 153,
   parameter int unsigned TAP_B     = 152,
   parameter int unsigned LOCK_CNT  = 64,
   parameter int unsigned WINDOW    = 256,
   parameter int unsigned ERR_LIMIT = 8,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             din,
   input  logic             din_vld,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       state
);

   localparam int unsigned FillW  = $clog2(WIDTH + 1);
   localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
   localparam int unsigned WinW   = $clog2(WINDOW + 1);
   localparam int unsigned ErrW   = $clog2(ERR_LIMIT + 1);

   typedef enum logic [1:0] {
      StSearch = 2'd0,
      StCheck  = 2'd1,
      StLocked = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic [FillW-1:0]   fill_cnt_q, fill_cnt_d;
   logic [MatchW-1:0]  match_cnt_q, match_cnt_d;
   logic [WinW-1:0]    win_cnt_q, win_cnt_d;
   logic [ErrW-1:0]    win_err_q, win_err_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic               err_q, err_d;

   logic pred;
   logic mismatch;
   logic r_zero;
   logic win_last;

   // Prediction from history (r_q[0] is the newest bit) and window-end detection.
   always_comb begin
      pred     = r_q[TAP_A-1] ^ r_q[TAP_B-1];
      mismatch = din ^ pred;
      r_zero   = (r_q == '0);
      win_last = (win_cnt_q == WinW'(WINDOW - 1));
   end

   // Next-state logic: acquisition, lock tracking and error accounting.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      fill_cnt_d  = fill_cnt_q;
      match_cnt_d = match_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      err_cnt_d   = err_cnt_q;
      err_d       = 1'b0;

      if (din_vld) begin
         case (state_q)
            StSearch: begin
               r_d = {r_q[WIDTH-2:0], din};
               if (fill_cnt_q == FillW'(WIDTH - 1)) begin
                  state_d     = StCheck;
                  fill_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  fill_cnt_d = fill_cnt_q + FillW'(1);
               end
            end

            StCheck: begin
               r_d = {r_q[WIDTH-2:0], din};
               // An all-zero history predicts zeros forever; never let it count as a match.
               if (mismatch || r_zero) begin
                  match_cnt_d = '0;
               end else if (match_cnt_q == MatchW'(LOCK_CNT - 1)) begin
                  state_d     = StLocked;
                  match_cnt_d = '0;
                  win_cnt_d   = '0;
                  win_err_d   = '0;
               end else begin
                  match_cnt_d = match_cnt_q + MatchW'(1);
               end
            end

            StLocked: begin
               // Shift the prediction, not the line bit, so a line error is seen only once.
               r_d   = {r_q[WIDTH-2:0], pred};
               err_d = mismatch;
               if (mismatch && !(&err_cnt_q)) begin
                  err_cnt_d = err_cnt_q + CNT_W'(1);
               end

               if (win_last) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + WinW'(1);
               end

               if (mismatch) begin
                  if (win_err_q == ErrW'(ERR_LIMIT - 1)) begin
                     // Loss of lock: history kept, fill restarts.
                     state_d    = StSearch;
                     fill_cnt_d = '0;
                     win_cnt_d  = '0;
                     win_err_d  = '0;
                  end else if (!win_last) begin
                     win_err_d = win_err_q + ErrW'(1);
                  end
               end
            end

            default: begin
               state_d     = StSearch;
               fill_cnt_d  = '0;
               match_cnt_d = '0;
               win_cnt_d   = '0;
               win_err_d   = '0;
            end
         endcase
      end

      // Clear takes priority over an error counted on the same edge.
      if (clr_cnt) begin
         err_cnt_d = '0;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q     <= StSearch;
         r_q         <= '0;
         fill_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         err_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         fill_cnt_q  <= fill_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         err_cnt_q   <= err_cnt_d;
         err_q       <= err_d;
      end
   end

   // Output mapping.
   always_comb begin
      locked  = (state_q == StLocked);
      err     = err_q;
      err_cnt = err_cnt_q;
      state   = state_q;
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: drives a reference LFSR stream, pushes the
// expected outputs for each driven bit into a scoreboard queue, and pops/compares
// them once the DUT has clocked the bit.

module tb_prbs_checker;

   logic        clk;
   logic        aclr_n;
   logic        din;
   logic        din_vld;
   logic        clr_cnt;
   logic        locked;
   logic        err;
   logic [31:0] err_cnt;
   logic [1:0]  state;

   typedef struct packed {
      logic        locked;
      logic        err;
      logic [31:0] cnt;
      logic [1:0]  st;
   } exp_t;

   exp_t         sb_q[$];
   logic [152:0] g;
   int           nv;
   int           n_chk;
   int           n_err;
   string        tag;

   prbs_checker dut (
      .clk     (clk),
      .aclr_n  (aclr_n),
      .din     (din),
      .din_vld (din_vld),
      .clr_cnt (clr_cnt),
      .locked  (locked),
      .err     (err),
      .err_cnt (err_cnt),
      .state   (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic l, input logic e, input int c, input int s);
      exp_t x;
      x.locked = l;
      x.err    = e;
      x.cnt    = c;
      x.st     = 2'(s);
      return x;
   endfunction

   // Expected state during acquisition after n valid bits.
   function automatic int acq_st(input int n);
      return (n < 153) ? 0 : ((n < 217) ? 1 : 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_chk++;
         n_err++;
         $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".locked"}, 32'(locked), 32'(e.locked));
         chk({tag, ".err"}, 32'(err), 32'(e.err));
         chk({tag, ".err_cnt"}, err_cnt, e.cnt);
         chk({tag, ".state"}, 32'(state), 32'(e.st));
      end
   endtask

   task automatic step(input logic vld, input logic b, input logic clr, input exp_t e);
      @(negedge clk);
      din     = b;
      din_vld = vld;
      clr_cnt = clr;
      sb_q.push_back(e);
      if (vld) nv++;
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic send(input logic flip, input logic clr, input exp_t e);
      logic b;
      b = g[152] ^ g[151];
      g = {g[151:0], b};
      step(1'b1, b ^ flip, clr, e);
   endtask

   // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
   task automatic pulse_reset(input string name);
      din_vld = 1'b0;
      clr_cnt = 1'b0;
      aclr_n  = 1'b0;
      #1;
      chk({name, ".locked"}, 32'(locked), 32'd0);
      chk({name, ".err"}, 32'(err), 32'd0);
      chk({name, ".err_cnt"}, err_cnt, 32'd0);
      chk({name, ".state"}, 32'(state), 32'd0);
      @(negedge clk);
      aclr_n = 1'b1;
      nv     = 0;
      g      = 153'h4;
   endtask

   initial begin
      exp_t prev;
      n_chk   = 0;
      n_err   = 0;
      nv      = 0;
      din     = 1'b0;
      din_vld = 1'b0;
      clr_cnt = 1'b0;
      aclr_n  = 1'b1;
      g       = 153'h4;
      #2;
      pulse_reset("reset");

      // Clean stream: lock after 217 valid bits, no errors over 10000 bits.
      tag = "clean";
      for (int n = 1; n <= 10000; n++) begin
         send(1'b0, 1'b0, mk(n >= 217, 1'b0, 0, acq_st(n)));
      end

      // Single inverted bit while locked.
      tag = "single";
      send(1'b1, 1'b0, mk(1'b1, 1'b1, 1, 2));
      tag = "single_after";
      for (int n = 0; n < 1000; n++) begin
         send(1'b0, 1'b0, mk(1'b1, 1'b0, 1, 2));
      end

      // Clear counter, align to a window start, then 8 errors inside one window.
      tag = "clr";
      send(1'b0, 1'b1, mk(1'b1, 1'b0, 0, 2));
      tag = "pad";
      while (((nv + 1 - 218) % 256) != 0) begin
         send(1'b0, 1'b0, mk(1'b1, 1'b0, 0, 2));
      end
      tag = "burst";
      for (int k = 0; k <= 14; k++) begin
         if (k == 14) send(1'b1, 1'b0, mk(1'b0, 1'b1, 8, 0));
         else if ((k % 2) == 0) send(1'b1, 1'b0, mk(1'b1, 1'b1, k / 2 + 1, 2));
         else send(1'b0, 1'b0, mk(1'b1, 1'b0, (k + 1) / 2, 2));
      end
      tag = "relock";
      for (int j = 1; j <= 217; j++) begin
         send(1'b0, 1'b0, mk(j >= 217, 1'b0, 8, acq_st(j)));
      end

      // All-zero stream must never lock.
      pulse_reset("reset_zero");
      tag = "zeros";
      for (int n = 1; n <= 2000; n++) begin
         step(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 0, (n < 153) ? 0 : 1));
      end

      // din_vld toggling: invalid cycles carry random data and must change nothing.
      pulse_reset("reset_vld");
      tag  = "toggle";
      prev = mk(1'b0, 1'b0, 0, 0);
      for (int v = 1; v <= 300; v++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'b0, prev);
         prev = mk(v >= 217, 1'b0, 0, acq_st(v));
         send(1'b0, 1'b0, prev);
      end

      // Five spaced errors, then async reset right after the last error pulse.
      tag = "five";
      for (int e = 1; e <= 5; e++) begin
         for (int n = 0; n < 20; n++) send(1'b0, 1'b0, mk(1'b1, 1'b0, e - 1, 2));
         send(1'b1, 1'b0, mk(1'b1, 1'b1, e, 2));
      end
      #2;
      pulse_reset("async_reset");

      // Relock, then an error coincident with clr_cnt.
      tag = "relock2";
      for (int n = 1; n <= 217; n++) begin
         send(1'b0, 1'b0, mk(n >= 217, 1'b0, 0, acq_st(n)));
      end
      tag = "clr_err";
      send(1'b1, 1'b1, mk(1'b1, 1'b1, 0, 2));
      tag = "err_after_clr";
      send(1'b1, 1'b0, mk(1'b1, 1'b1, 1, 2));
      tag = "tail";
      for (int n = 0; n < 4; n++) begin
         send(1'b0, 1'b0, mk(1'b1, 1'b0, 1, 2));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
